// File: rtl/rf_multiport.sv
// rf_multiport: DW x 2^AW register file for the decode stage.
//
// NRD combinational read ports behind registered read addresses, one write
// port staged for a cycle before it reaches the array, staged-write bypass, a
// read-address hold for pipeline stalls, and a hardware clear sequencer that
// zeroes the array after every reset.
//
// Optional feature macro: RF_SHADOW_BANK_EN adds a second (interrupt-shadow)
// bank selected by bank_sel for both reads and writes.
//
// Ports:
//   clk       clock, all state changes on the rising edge
//   rst       asynchronous active-high reset; restarts the clear sequence
//   wr_data   write data (DW)
//   wr_addr   write address (AW)
//   wr_en     write request, sampled every edge, ignored while clearing
//   rd_addr   packed read addresses, port k at [k*AW +: AW]
//   rd_hold   keep the read-address registers (stall)
//   bank_sel  bank for reads and writes (RF_SHADOW_BANK_EN only)
//   rd_data   packed read data, port k at [k*DW +: DW]
//   clr_busy  clear sequencer active; reads return 0 while high
module rf_multiport #(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NRD      = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     wr_data,
  input  logic [AW-1:0]     wr_addr,
  input  logic              wr_en,
  input  logic [NRD*AW-1:0] rd_addr,
  input  logic              rd_hold,
`ifdef RF_SHADOW_BANK_EN
  input  logic              bank_sel,
`endif
  output logic [NRD*DW-1:0] rd_data,
  output logic              clr_busy
);

  localparam int unsigned DEPTH = 1 << AW;

`ifdef RF_SHADOW_BANK_EN
  localparam int unsigned NBANK = 2;
  localparam int unsigned IW    = AW + 1;
`else
  localparam int unsigned NBANK = 1;
  localparam int unsigned IW    = AW;
`endif

  typedef enum logic {StClear, StRun} state_e;

  state_e state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // Write staging stage.
  logic          s_en_q, s_en_d;
  logic [AW-1:0] s_addr_q;
  logic [DW-1:0] s_data_q;

  // Read-address registers, packed like rd_addr.
  logic [NRD*AW-1:0] r_addr_q;

`ifdef RF_SHADOW_BANK_EN
  logic s_bank_q;
  logic r_bank_q;
`endif

  // Bank b, address a lives at index {b, a}.
  logic [DW-1:0] mem [NBANK*DEPTH];

  logic [IW-1:0] w_idx;
  logic [IW-1:0] clr_idx;
  logic          s_zero;

  assign clr_busy = (state_q == StClear);

  // ---------------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StClear: begin
        // Explicit terminal compare: leave after entry DEPTH-1 is written.
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      StRun:   state_d = StRun;
      default: state_d = StClear;
    endcase
  end

  // Write requests are dropped while the array is being cleared.
  assign s_en_d = wr_en & (state_q == StRun);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StClear;
      cnt_q    <= '0;
      s_en_q   <= 1'b0;
      s_addr_q <= '0;
      s_data_q <= '0;
      r_addr_q <= '0;
`ifdef RF_SHADOW_BANK_EN
      s_bank_q <= 1'b0;
      r_bank_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      s_en_q   <= s_en_d;
      s_addr_q <= wr_addr;
      s_data_q <= wr_data;
`ifdef RF_SHADOW_BANK_EN
      s_bank_q <= bank_sel;
`endif
      if (!rd_hold) begin
        r_addr_q <= rd_addr;
`ifdef RF_SHADOW_BANK_EN
        r_bank_q <= bank_sel;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Array write: clear sequencer has priority, otherwise commit the staged write
  // ---------------------------------------------------------------------------
`ifdef RF_SHADOW_BANK_EN
  assign w_idx   = {s_bank_q, s_addr_q};
  assign clr_idx = {1'b0, cnt_q};
`else
  assign w_idx   = s_addr_q;
  assign clr_idx = cnt_q;
`endif

  assign s_zero = ZERO_REG && (s_addr_q == '0);

  // No reset on the storage itself; the clear sequencer zeroes it instead.
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      mem[clr_idx] <= '0;
`ifdef RF_SHADOW_BANK_EN
      mem[{1'b1, cnt_q}] <= '0;
`endif
    end else if (s_en_q && !s_zero) begin
      mem[w_idx] <= s_data_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports: clear > zero register > staged-write bypass > array
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic [IW-1:0] ri;
    logic          hit;
    logic [DW-1:0] rd;

    assign ra = r_addr_q[k*AW +: AW];

`ifdef RF_SHADOW_BANK_EN
    assign ri  = {r_bank_q, ra};
    assign hit = s_en_q && (s_addr_q == ra) && (s_bank_q == r_bank_q);
`else
    assign ri  = ra;
    assign hit = s_en_q && (s_addr_q == ra);
`endif

    always_comb begin
      rd = mem[ri];
      if (clr_busy) begin
        rd = '0;
      end else if (ZERO_REG && (ra == '0)) begin
        rd = '0;
      end else if (hit) begin
        rd = s_data_q;
      end
    end

    assign rd_data[k*DW +: DW] = rd;
  end

endmodule

// File: tb/tb_rf_multiport.sv
// Self-checking bench for rf_multiport (DW=32, AW=5, NRD=2, ZERO_REG=1).
// The reference model tracks architectural register contents: a write becomes
// visible to reads right after the edge that samples it, writes are dropped
// while the clear (DEPTH edges after reset) is in progress, and reset zeroes
// everything.
module tb_rf_multiport;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NRD   = 2;
  localparam int unsigned DEPTH = 32;
`ifdef RF_SHADOW_BANK_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DW-1:0]     wr_data = '0;
  logic [AW-1:0]     wr_addr = '0;
  logic              wr_en = 1'b0;
  logic [NRD*AW-1:0] rd_addr = '0;
  logic              rd_hold = 1'b0;
`ifdef RF_SHADOW_BANK_EN
  logic              bank_sel = 1'b0;
`endif
  logic [NRD*DW-1:0] rd_data;
  logic              clr_busy;

  rf_multiport #(
    .DW      (DW),
    .AW      (AW),
    .NRD     (NRD),
    .ZERO_REG(1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_data (wr_data),
    .wr_addr (wr_addr),
    .wr_en   (wr_en),
    .rd_addr (rd_addr),
    .rd_hold (rd_hold),
`ifdef RF_SHADOW_BANK_EN
    .bank_sel(bank_sel),
`endif
    .rd_data (rd_data),
    .clr_busy(clr_busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state.
  logic [DW-1:0] m_mem [2][DEPTH];
  int            m_edges;       // edges since reset release
  logic [AW-1:0] m_ra [NRD];
  logic          m_rb;

  function automatic bit m_busy();
    return m_edges < DEPTH;
  endfunction

  function automatic logic [DW-1:0] m_read(input int k);
    if (m_busy()) return '0;
    if (m_ra[k] == 0) return '0;
    return m_mem[m_rb][m_ra[k]];
  endfunction

  task automatic model_reset();
    m_edges = 0;
    m_rb    = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < DEPTH; i++) m_mem[b][i] = '0;
    for (int k = 0; k < NRD; k++) m_ra[k] = '0;
  endtask

  function automatic logic [DW-1:0] rd_port(input int k);
    return rd_data[k*DW +: DW];
  endfunction

  // One clock: drive inputs, take the edge, advance the model, check outputs.
  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                      input logic hold, input logic bank);
    logic b;
    b       = bank & SHADOW;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    rd_addr = {ra1, ra0};
    rd_hold = hold;
`ifdef RF_SHADOW_BANK_EN
    bank_sel = b;
`endif
    @(posedge clk);
    if (m_busy()) m_edges++;
    else if (we && wa != 0) m_mem[b][wa] = wd;
    if (!hold) begin
      m_ra[0] = ra0;
      m_ra[1] = ra1;
      m_rb    = b;
    end
    #1;
    check_eq("clr_busy", {63'd0, clr_busy}, {63'd0, m_busy()});
    check_eq("rd0", {32'd0, rd_port(0)}, {32'd0, m_read(0)});
    check_eq("rd1", {32'd0, rd_port(1)}, {32'd0, m_read(1)});
  endtask

  // Asserts reset away from an edge, holds it across one edge, releases it.
  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #2;
    check_eq("rst_busy", {63'd0, clr_busy}, 64'd1);
    check_eq("rst_rd0", {32'd0, rd_port(0)}, 64'd0);
    check_eq("rst_rd1", {32'd0, rd_port(1)}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Steps with the given write request until clr_busy drops; returns edge count.
  task automatic run_clear(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                           output int n);
    n = 0;
    while (clr_busy && n < 100) begin
      step(we, wa, wd, AW'(n), AW'(DEPTH - 1 - n), 1'b0, 1'b0);
      n++;
    end
  endtask

  initial begin
    int n;
    do_reset();

    // Clear length, with a write to r3 requested the whole time.
    run_clear(1'b1, 5'd3, 32'hDEAD_BEEF, n);
    check_eq("clr_len", 64'(n), 64'(DEPTH));

    // Every entry reads 0 after the clear; r3 write was ignored.
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, '0, AW'(i), AW'(DEPTH - 1 - i), 1'b0, 1'b0);
    step(1'b0, '0, '0, 5'd3, 5'd3, 1'b0, 1'b0);
    check_eq("clr_ignored_wr", {32'd0, rd_port(0)}, 64'd0);

    // Bypass: write r7 and read it with the address sampled on the same edge.
    step(1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd0, 1'b0, 1'b0);
    check_eq("bypass_p0", {32'd0, rd_port(0)}, 64'h1234_5678);
    step(1'b0, '0, '0, 5'd7, 5'd7, 1'b0, 1'b0);
    check_eq("array_p0", {32'd0, rd_port(0)}, 64'h1234_5678);
    check_eq("array_p1", {32'd0, rd_port(1)}, 64'h1234_5678);

    // Zero register, including the bypass window.
    step(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b0, 1'b0);
    check_eq("zero_byp_p0", {32'd0, rd_port(0)}, 64'd0);
    check_eq("zero_byp_p1", {32'd0, rd_port(1)}, 64'd0);
    step(1'b0, '0, '0, 5'd0, 5'd0, 1'b0, 1'b0);
    check_eq("zero_arr_p0", {32'd0, rd_port(0)}, 64'd0);

    // Hold: port 0 stays on r5 and sees the later write to it.
    step(1'b1, 5'd9, 32'h0000_0099, 5'd0, 5'd0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 5'd5, 5'd0, 1'b0, 1'b0);
    step(1'b1, 5'd5, 32'hA5A5_A5A5, 5'd9, 5'd0, 1'b1, 1'b0);
    check_eq("hold_bypass", {32'd0, rd_port(0)}, 64'hA5A5_A5A5);
    step(1'b0, '0, '0, 5'd9, 5'd0, 1'b1, 1'b0);
    check_eq("hold_array", {32'd0, rd_port(0)}, 64'hA5A5_A5A5);
    step(1'b0, '0, '0, 5'd9, 5'd0, 1'b0, 1'b0);
    check_eq("hold_release", {32'd0, rd_port(0)}, 64'h0000_0099);

    // Reset between staging and commit: the write is lost, clear restarts.
    step(1'b1, 5'd12, 32'hCAFE_F00D, 5'd12, 5'd12, 1'b0, 1'b0);
    check_eq("pre_rst_byp", {32'd0, rd_port(0)}, 64'hCAFE_F00D);
    do_reset();
    run_clear(1'b0, '0, '0, n);
    check_eq("clr_len2", 64'(n), 64'(DEPTH));
    step(1'b0, '0, '0, 5'd12, 5'd7, 1'b0, 1'b0);
    check_eq("rst_lost_wr", {32'd0, rd_port(0)}, 64'd0);
    check_eq("rst_cleared", {32'd0, rd_port(1)}, 64'd0);

`ifdef RF_SHADOW_BANK_EN
    step(1'b1, 5'd4, 32'h1, 5'd0, 5'd0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 5'd4, 5'd0, 1'b0, 1'b0);
    check_eq("bank0_r4", {32'd0, rd_port(0)}, 64'd0);
    step(1'b0, '0, '0, 5'd4, 5'd0, 1'b0, 1'b1);
    check_eq("bank1_r4", {32'd0, rd_port(0)}, 64'd1);
`endif

    // Random traffic; narrow write addresses to hit bypass and overwrites often.
    for (int i = 0; i < 600; i++) begin
      logic [AW-1:0] wa;
      if (i == 300) begin
        do_reset();
        run_clear(1'($urandom), AW'($urandom), $urandom, n);
        check_eq("clr_len_rand", 64'(n), 64'(DEPTH));
      end
      wa = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      step(1'($urandom_range(0, 2) != 0), wa, $urandom,
           AW'($urandom_range(0, 9)), AW'($urandom), ($urandom_range(0, 3) == 0),
           1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time guard.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
